// File: rtl/ifmap_window_addr_gen.sv
// IFMAP scratchpad read-address generator: walks every filter window of one row
// across all channels and issues addresses on a circular scratchpad over valid/ready.
module ifmap_window_addr_gen #(
    parameter int POINTER_SIZE         = 8,
    parameter int SP_DEPTH             = 256,
    parameter int FILTER_SIZE_REG_SIZE = 8,
    parameter int STRIDE_SIZE          = 3,
    parameter int DILATION_SIZE        = 2,
    parameter int CHANNEL_SIZE         = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            abort,
    input  logic [POINTER_SIZE-1:0]         base_ptr,
    input  logic [FILTER_SIZE_REG_SIZE-1:0] row_len,
    input  logic [POINTER_SIZE-1:0]         channel_pitch,
    input  logic [FILTER_SIZE_REG_SIZE-1:0] filter_size,
    input  logic [STRIDE_SIZE-1:0]          stride,
    input  logic [DILATION_SIZE-1:0]        dilation,
    input  logic [CHANNEL_SIZE-1:0]         num_channels,
    output logic [POINTER_SIZE-1:0]         read_pointer,
    output logic                            addr_valid,
    input  logic                            addr_ready,
    output logic                            tap_last,
    output logic                            window_last,
    output logic                            row_done,
    output logic                            busy
);

    localparam int P  = POINTER_SIZE;
    localparam int F  = FILTER_SIZE_REG_SIZE;
    localparam int S  = STRIDE_SIZE;
    localparam int D  = DILATION_SIZE;
    localparam int C  = CHANNEL_SIZE;
    // Window-offset arithmetic width: holds row offset + stride + full tap span.
    localparam int SW = F + D + 2;
    localparam logic [P:0] DEPTH = (P+1)'(SP_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nx;

    logic [F-1:0]  fs_r, len_r, k_r;
    logic [C-1:0]  nch_r, c_r;
    logic [S-1:0]  stride_r;
    logic [D-1:0]  dil_r;
    logic [P-1:0]  pitch_r;
    logic [SW-1:0] span_r, woff_r;
    logic [P-1:0]  win_r, chb_r, ptr_r;

    logic [S-1:0]  stride_eff;
    logic [D-1:0]  dil_eff;
    logic [C-1:0]  nch_eff;
    logic [SW-1:0] span_in;
    logic          zero_win;
    logic          tap_end, ch_end, more_win, beat, launch;
    logic [P-1:0]  ptr_tap, chb_nx, win_nx;

    function automatic logic [P-1:0] wrap(input logic [P:0] sum);
        if (sum >= DEPTH)
            return P'(sum - DEPTH);
        else
            return sum[P-1:0];
    endfunction

    assign stride_eff = (stride == '0)       ? S'(1) : stride;
    assign dil_eff    = (dilation == '0)     ? D'(1) : dilation;
    assign nch_eff    = (num_channels == '0) ? C'(1) : num_channels;
    assign span_in    = SW'(filter_size - F'(1)) * SW'(dil_eff);
    assign zero_win   = (filter_size == '0) || (span_in >= SW'(row_len));

    assign tap_end  = (k_r == fs_r - F'(1));
    assign ch_end   = (c_r == nch_r - C'(1));
    assign more_win = (woff_r + SW'(stride_r) + span_r) < SW'(len_r);
    assign beat     = (state == RUN) && addr_ready;
    assign launch   = (state == IDLE) && start && !abort;

    assign ptr_tap = wrap({1'b0, ptr_r} + (P+1)'(dil_r));
    assign chb_nx  = wrap({1'b0, chb_r} + {1'b0, pitch_r});
    assign win_nx  = wrap({1'b0, win_r} + (P+1)'(stride_r));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = zero_win ? DONE : RUN;
            RUN:     if (beat && tap_end && ch_end && !more_win) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // Abort overrides everything, including a simultaneous start.
        if (abort)
            state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fs_r     <= '0;
            len_r    <= '0;
            nch_r    <= '0;
            stride_r <= '0;
            dil_r    <= '0;
            pitch_r  <= '0;
            span_r   <= '0;
            k_r      <= '0;
            c_r      <= '0;
            woff_r   <= '0;
            win_r    <= '0;
            chb_r    <= '0;
            ptr_r    <= '0;
        end else if (launch) begin
            fs_r     <= filter_size;
            len_r    <= row_len;
            nch_r    <= nch_eff;
            stride_r <= stride_eff;
            dil_r    <= dil_eff;
            pitch_r  <= channel_pitch;
            span_r   <= span_in;
            k_r      <= '0;
            c_r      <= '0;
            woff_r   <= '0;
            win_r    <= base_ptr;
            chb_r    <= base_ptr;
            ptr_r    <= base_ptr;
        end else if (beat && !abort) begin
            if (!tap_end) begin
                k_r   <= k_r + F'(1);
                ptr_r <= ptr_tap;
            end else if (!ch_end) begin
                k_r   <= '0;
                c_r   <= c_r + C'(1);
                chb_r <= chb_nx;
                ptr_r <= chb_nx;
            end else if (more_win) begin
                k_r    <= '0;
                c_r    <= '0;
                woff_r <= woff_r + SW'(stride_r);
                win_r  <= win_nx;
                chb_r  <= win_nx;
                ptr_r  <= win_nx;
            end
        end
    end

    assign read_pointer = ptr_r;
    assign addr_valid   = (state == RUN);
    assign tap_last     = addr_valid && tap_end;
    assign window_last  = tap_last && ch_end;
    assign row_done     = (state == DONE);
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_ifmap_window_addr_gen.sv
// Directed bench for ifmap_window_addr_gen on a 16-entry scratchpad.
module tb_ifmap_window_addr_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, addr_ready;
    logic [7:0] base_ptr, row_len, channel_pitch, filter_size;
    logic [2:0] stride;
    logic [1:0] dilation;
    logic [3:0] num_channels;
    logic [7:0] read_pointer;
    logic       addr_valid, tap_last, window_last, row_done, busy;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    ifmap_window_addr_gen #(
        .POINTER_SIZE(8), .SP_DEPTH(16), .FILTER_SIZE_REG_SIZE(8),
        .STRIDE_SIZE(3), .DILATION_SIZE(2), .CHANNEL_SIZE(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .base_ptr(base_ptr), .row_len(row_len), .channel_pitch(channel_pitch),
        .filter_size(filter_size), .stride(stride), .dilation(dilation),
        .num_channels(num_channels), .read_pointer(read_pointer),
        .addr_valid(addr_valid), .addr_ready(addr_ready), .tap_last(tap_last),
        .window_last(window_last), .row_done(row_done), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int base, input int len, input int fs, input int str,
                           input int dil, input int ch, input int pitch);
        base_ptr      = 8'(base);
        row_len       = 8'(len);
        filter_size   = 8'(fs);
        stride        = 3'(str);
        dilation      = 2'(dil);
        num_channels  = 4'(ch);
        channel_pitch = 8'(pitch);
    endtask

    // ready_mode 0: always ready; 1: ready on every third cycle (1,0,0,...).
    task automatic run_row(input string name, input int fs, input int ch,
                           input int ready_mode, input bit mid_start);
        int         idx = 0;
        int         cyc = 0;
        int         last_acc = -10;
        bit         done = 0;
        bit         stalled = 0;
        logic [7:0] held_ptr = '0;
        logic       held_tl = 1'b0, held_wl = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_valid_latency"}, addr_valid, 1);
        while (!done && cyc < 300) begin
            addr_ready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (mid_start) begin
                start = (cyc == 2);
                if (cyc == 2) begin
                    base_ptr    = 8'd9;
                    filter_size = 8'd1;
                end
            end
            if (row_done) begin
                check({name, "_beat_count"}, idx, exp_q.size());
                check({name, "_done_timing"}, cyc - last_acc, 1);
                done = 1;
            end else if (addr_valid) begin
                if (stalled) begin
                    check({name, "_hold_ptr"}, read_pointer, held_ptr);
                    check({name, "_hold_flags"}, {tap_last, window_last}, {held_tl, held_wl});
                end
                if (addr_ready) begin
                    if (idx < exp_q.size()) begin
                        check($sformatf("%s_ptr%0d", name, idx), read_pointer, exp_q[idx]);
                        check($sformatf("%s_tap_last%0d", name, idx), tap_last, (idx % fs) == fs - 1);
                        check($sformatf("%s_win_last%0d", name, idx), window_last,
                              (idx % (fs * ch)) == fs * ch - 1);
                    end else begin
                        check({name, "_extra_beat"}, idx, exp_q.size() - 1);
                    end
                    idx++;
                    last_acc = cyc;
                    stalled  = 0;
                end else begin
                    stalled  = 1;
                    held_ptr = read_pointer;
                    held_tl  = tap_last;
                    held_wl  = window_last;
                end
            end else begin
                check({name, "_valid_dropped"}, addr_valid, 1);
            end
            @(negedge clk);
            cyc++;
        end
        addr_ready = 1'b0;
        start      = 1'b0;
        if (!done)
            check({name, "_timeout"}, 0, 1);
        check({name, "_done_pulse_width"}, row_done, 0);
        check({name, "_idle_after"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; addr_ready = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("reset_outputs", {read_pointer, addr_valid, tap_last, window_last, row_done, busy}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", busy, 0);

        // T1: one channel, unit stride/dilation
        set_cfg(0, 5, 3, 1, 1, 1, 8);
        exp_q = '{0, 1, 2, 1, 2, 3, 2, 3, 4};
        run_row("t1", 3, 1, 0, 1'b0);

        // T2: stride 2, dilation 3; start pulsed mid-row with altered inputs
        set_cfg(0, 8, 2, 2, 3, 1, 8);
        exp_q = '{0, 3, 2, 5, 4, 7};
        run_row("t2", 2, 1, 0, 1'b1);

        // T3: two channels, wrap past scratchpad end
        set_cfg(14, 4, 3, 1, 1, 2, 8);
        exp_q = '{14, 15, 0, 6, 7, 8, 15, 0, 1, 7, 8, 9};
        run_row("t3", 3, 2, 0, 1'b0);

        // T4: T1 with back-pressure
        set_cfg(0, 5, 3, 1, 1, 1, 8);
        exp_q = '{0, 1, 2, 1, 2, 3, 2, 3, 4};
        run_row("t4", 3, 1, 1, 1'b0);

        // T5: abort after 4 accepted beats, then restart
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        addr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_ptr%0d", i), read_pointer, exp_q[i]);
            @(negedge clk);
        end
        addr_ready = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_valid_after_abort", addr_valid, 0);
        check("t5_busy_after_abort", busy, 0);
        for (int i = 0; i < 3; i++) begin
            check("t5_no_row_done", row_done, 0);
            @(negedge clk);
        end
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("t5_abort_beats_start", busy, 0);
        run_row("t5_restart", 3, 1, 0, 1'b0);

        // T6: zero windows; start during DONE is ignored
        set_cfg(0, 3, 4, 1, 1, 1, 8);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("t6_row_done", row_done, 1);
        check("t6_no_valid", addr_valid, 0);
        check("t6_busy", busy, 1);
        @(negedge clk);
        start = 1'b0;
        check("t6_done_once", row_done, 0);
        check("t6_idle", busy, 0);
        check("t6_no_valid2", addr_valid, 0);

        // T7: zero stride/dilation/channels behave as 1
        set_cfg(0, 5, 3, 0, 0, 0, 8);
        exp_q = '{0, 1, 2, 1, 2, 3, 2, 3, 4};
        run_row("t7", 3, 1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
